// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready pipeline computing a bitwise AND/OR/XOR/NOR with a zero flag
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_result_q, s1_result_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s1_adv, s2_adv, in_fire, s2_load;
  logic [WIDTH-1:0] op_res;
  // stage advance conditions, operation decode and next-state for both stages
  always_comb begin
    s2_adv      = !s2_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    in_fire     = in_valid && s1_adv;
    op_res      = in_op == 2'b00 ? (in_a & in_b) :
                  in_op == 2'b01 ? (in_a | in_b) :
                  in_op == 2'b10 ? (in_a ^ in_b) : ~(in_a | in_b);
    s1_valid_d  = s1_adv ? in_fire : s1_valid_q;
    s1_result_d = in_fire ? op_res : s1_result_q;
    s2_load     = s2_adv && s1_valid_q;
    s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
    s2_result_d = s2_load ? s1_result_q : s2_result_q;
    s2_zero_d   = s2_load ? ~|s1_result_q : s2_zero_q;
  end
  // pipeline registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_result_q <= s1_result_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
    end
  end
  assign in_ready   = s1_adv;
  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits (>= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a valid operation this cycle.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 in_a  input  WIDTH  first operand.
REQ-007 in_b  input  WIDTH  second operand.
REQ-008 in_op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 out_result  output  WIDTH  registered bitwise result.
REQ-012 out_zero  output  1  high when out_result is all zeros.

Function
REQ-013 Two pipeline stages, S1 and S2, each holding a valid bit and a WIDTH-bit result; S2 also holds a zero flag.
REQ-014 Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
REQ-015 s2_adv = !S2.valid || out_ready; s1_adv = !S1.valid || s2_adv; in_ready = s1_adv (combinational, no dependence on in_valid).
REQ-016 On an input transfer, S1.result <= op(in_a, in_b) per REQ-008, bitwise across all WIDTH bits, and S1.valid <= 1.
REQ-017 On s1_adv without an input transfer, S1.valid <= 0.
REQ-018 When s2_adv, S2.valid <= S1.valid; S2.result and S2.zero load from S1 (zero = ~|S1.result) only when S1.valid.
REQ-019 When !s2_adv, S2 holds; when !s1_adv, S1 holds; held data is stable.
REQ-020 out_valid = S2.valid; out_result = S2.result; out_zero = S2.zero.
REQ-021 Latency: operation accepted in cycle N appears on outputs in cycle N+2 with no backpressure.
REQ-022 Throughput: one operation per cycle while out_ready stays high.
REQ-023 Order preserved; no operation dropped or duplicated under any out_ready pattern.
REQ-024 Full (both stages valid, out_ready low): in_ready = 0, no state change.
REQ-025 Full with out_ready high: output, S2<-S1, and new input accepted in the same cycle.
REQ-026 Empty: out_valid = 0; out_result and out_zero are don't-care but stable.
REQ-027 in_op, in_a, in_b are ignored when no input transfer occurs.

Reset
REQ-028 While reset is high at a rising edge: S1.valid, S2.valid <= 0; S1.result, S2.result <= 0; S2.zero <= 1.
REQ-029 After reset: out_valid = 0, out_result = 0, out_zero = 1, in_ready = 1.
REQ-030 Reset overrides any simultaneous transfer; in-flight operations are discarded and none emerge later.

Verification
REQ-031 WIDTH=32, out_ready=1, a=0xF0F0_1234, b=0x0FF0_FFFF, ops 00,01,10,11 in consecutive cycles -> outputs from cycle 2: 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0x000F_0000, out_zero=0 each.
REQ-032 a=0xAAAA_AAAA, b=0x5555_5555, op=00 -> out_result=0, out_zero=1; same operands op=11 -> 0, out_zero=1.
REQ-033 Three ops issued back to back, out_ready=0 -> in_ready drops after the second; third held upstream; raising out_ready drains all three in order, one per cycle.
REQ-034 Both stages full, out_ready=1, in_valid=1 -> one result out and one new op in the same cycle, out_valid stays 1.
REQ-035 Reset asserted with two ops in flight -> next cycle out_valid=0, out_zero=1, in_ready=1; no stale result ever appears.
REQ-036 WIDTH=8, a=0xFF, b=0xFF, op=10 -> 0x00, out_zero=1; op=11 -> 0x00, out_zero=1.
